// File: rtl/bitmap_vram_arbiter.sv
// bitmap_vram_arbiter: shares one synchronous video RAM port between the CPU
// and the video scan. Slots alternate on every ce (0 = CPU, 1 = video).
// Single-pixel CPU writes are done as a read-modify-write across two CPU slots.
module bitmap_vram_arbiter #(
   parameter int  PIX_W     = 4,
   parameter int  HS_W      = 8,
   parameter int  VS_W      = 8,
   parameter int  ADDR_W    = 15,
   parameter int  PROT_BITS = 3,
   localparam int LP        = $clog2(8 / PIX_W),
   localparam int LPW       = (LP > 0) ? LP : 1
) (
   input  logic              clk,
   input  logic              RESETn,
   input  logic              ce,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_bitmode,
   input  logic [LPW-1:0]    cpu_pix,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              cpu_ack,
   input  logic [HS_W-1:0]   hs,
   input  logic [VS_W-1:0]   vs,
   output logic [PIX_W-1:0]  pix_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_din,
   input  logic [7:0]        mem_dout
);

   typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_ISSUE, S_ACK} state_e;

   state_e            state_q;
   logic              slot_q;
   logic              we_q, bm_q;
   logic [LPW-1:0]    pix_q;
   logic [ADDR_W-1:0] addr_q;
   logic [PIX_W-1:0]  pixd_q;
   logic [7:0]        rdbuf_q;
   logic [LPW-1:0]    vidx_q;
   logic              vvalid_q;
   logic              cpu_ack_q;
   logic [7:0]        cpu_dout_q;
   logic [PIX_W-1:0]  pix_out_q;

   logic              plain_wr;
   logic [ADDR_W-1:0] vid_addr;

   // Bit offset of pixel field idx; field 0 sits in the MSBs.
   function automatic int field_shift(input logic [LPW-1:0] idx);
      int i;
      i = (PIX_W == 8) ? 0 : int'(idx);
      return 8 - (i + 1) * PIX_W;
   endfunction

   function automatic logic [PIX_W-1:0] get_field(input logic [7:0] b, input logic [LPW-1:0] idx);
      logic [7:0] t;
      t = b >> field_shift(idx);
      return t[PIX_W-1:0];
   endfunction

   function automatic logic [7:0] put_field(input logic [7:0] b, input logic [LPW-1:0] idx,
                                            input logic [PIX_W-1:0] p);
      logic [7:0] m, v;
      m = (8'hFF >> (8 - PIX_W)) << field_shift(idx);
      v = 8'(p) << field_shift(idx);
      return (b & ~m) | v;
   endfunction

   // Pixel value placed in the MSBs of a byte, remaining bits zero.
   function automatic logic [7:0] left_align(input logic [PIX_W-1:0] p);
      logic [7:0] t;
      t = 8'(p);
      return t << (8 - PIX_W);
   endfunction

   assign plain_wr = cpu_req & cpu_we & ~cpu_bitmode;
   assign vid_addr = {vs, hs[HS_W-1:LP]};

   // RAM port steering: live CPU address while idle so acceptance can issue immediately.
   always_comb begin
      // NOTE: a default assignment first keeps every path covered, so no latch is inferred.
      mem_addr = cpu_addr;
      if (slot_q)
         mem_addr = vid_addr;
      else if (state_q != S_IDLE)
         mem_addr = addr_q;
   end

   // Write strobe is gated by RESETn so a reset mid-operation can never write.
   assign mem_we  = ce & ~slot_q & RESETn &
                    (((state_q == S_IDLE) & plain_wr) | (state_q == S_WR_ISSUE));
   assign mem_din = (state_q == S_WR_ISSUE) ? put_field(rdbuf_q, pix_q, pixd_q) : cpu_din;

   // Slot phasing and video pixel pipeline.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         slot_q    <= 1'b0;
         vidx_q    <= '0;
         vvalid_q  <= 1'b0;
         pix_out_q <= '0;
      end else if (ce) begin
         slot_q <= ~slot_q;
         if (slot_q) begin
            vidx_q   <= hs[LPW-1:0];
            vvalid_q <= 1'b1;
         end else if (vvalid_q) begin
            pix_out_q <= get_field(mem_dout, vidx_q);
         end
      end
   end

   // CPU request FSM with registered ack and read data.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         bm_q       <= 1'b0;
         pix_q      <= '0;
         addr_q     <= '0;
         pixd_q     <= '0;
         rdbuf_q    <= '0;
         cpu_ack_q  <= 1'b0;
         cpu_dout_q <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (ce && !slot_q && cpu_req) begin
                  we_q   <= cpu_we;
                  bm_q   <= cpu_bitmode;
                  pix_q  <= cpu_pix;
                  addr_q <= cpu_addr;
                  pixd_q <= cpu_din[7 -: PIX_W];
                  if (plain_wr) begin
                     state_q   <= S_ACK;
                     cpu_ack_q <= 1'b1;
                  end else begin
                     state_q <= S_RD_WAIT;
                  end
               end
            end
            S_RD_WAIT: begin
               if (ce && slot_q) begin
                  rdbuf_q <= mem_dout;
                  if (!we_q) begin
                     cpu_dout_q <= bm_q ? left_align(get_field(mem_dout, pix_q)) : mem_dout;
                     state_q    <= S_ACK;
                     cpu_ack_q  <= 1'b1;
                  end else if (addr_q[ADDR_W-1 -: PROT_BITS] == '0) begin
                     state_q   <= S_ACK;
                     cpu_ack_q <= 1'b1;
                  end else begin
                     state_q <= S_WR_ISSUE;
                  end
               end
            end
            S_WR_ISSUE: begin
               if (ce && !slot_q) begin
                  state_q   <= S_ACK;
                  cpu_ack_q <= 1'b1;
               end
            end
            S_ACK: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_ack  = cpu_ack_q;
   assign cpu_dout = cpu_dout_q;
   assign pix_out  = pix_out_q;

endmodule

// File: tb/tb_bitmap_vram_arbiter.sv
// Directed bench for bitmap_vram_arbiter: 4-bpp instance with CPU traffic,
// plus a 2-bpp instance exercising the video path only.
module tb_bitmap_vram_arbiter;

   logic        clk = 1'b0;
   logic        RESETn;
   logic        ce;
   logic        cpu_req, cpu_we, cpu_bitmode;
   logic [0:0]  cpu_pix;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_din, cpu_dout;
   logic        cpu_ack;
   logic [7:0]  hs, vs;
   logic [3:0]  pix_out;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_din, mem_dout;

   // second instance, 2 bpp, CPU side idle
   logic        req2 = 1'b0, we2 = 1'b0, bm2 = 1'b0;
   logic [1:0]  pix2 = '0;
   logic [13:0] addr2 = '0;
   logic [7:0]  din2 = '0, dout2;
   logic        ack2;
   logic [1:0]  pix_out2;
   logic [13:0] mem_addr2;
   logic        mem_we2;
   logic [7:0]  mem_din2, mem_dout2;

   logic [7:0]  ram  [0:32767];
   logic [7:0]  ram2 [0:16383];
   logic        bd_en = 1'b0, bd2_en = 1'b0;
   logic [14:0] bd_addr = '0;
   logic [13:0] bd2_addr = '0;
   logic [7:0]  bd_data = '0;

   logic        tb_slot;
   int          we_cnt = 0, vid_we_cnt = 0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   bitmap_vram_arbiter #(.PIX_W(4), .HS_W(8), .VS_W(8), .ADDR_W(15), .PROT_BITS(3)) dut (
      .clk(clk), .RESETn(RESETn), .ce(ce),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bitmode(cpu_bitmode), .cpu_pix(cpu_pix),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
      .hs(hs), .vs(vs), .pix_out(pix_out),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   bitmap_vram_arbiter #(.PIX_W(2), .HS_W(8), .VS_W(8), .ADDR_W(14), .PROT_BITS(3)) dut2 (
      .clk(clk), .RESETn(RESETn), .ce(ce),
      .cpu_req(req2), .cpu_we(we2), .cpu_bitmode(bm2), .cpu_pix(pix2),
      .cpu_addr(addr2), .cpu_din(din2), .cpu_dout(dout2), .cpu_ack(ack2),
      .hs(hs), .vs(vs), .pix_out(pix_out2),
      .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_din(mem_din2), .mem_dout(mem_dout2)
   );

   // RAM models: one-clk read latency, advancing on ce; backdoor preload port
   always @(posedge clk) begin
      if (bd_en) ram[bd_addr] <= bd_data;
      if (ce) begin
         if (mem_we) ram[mem_addr] <= mem_din;
         mem_dout <= ram[mem_addr];
      end
   end

   always @(posedge clk) begin
      if (bd2_en) ram2[bd2_addr] <= bd_data;
      if (ce) begin
         if (mem_we2) ram2[mem_addr2] <= mem_din2;
         mem_dout2 <= ram2[mem_addr2];
      end
   end

   // independent slot model: the value here at a negedge is the slot of the next posedge
   always @(posedge clk or negedge RESETn) begin
      if (!RESETn) tb_slot <= 1'b0;
      else if (ce) tb_slot <= ~tb_slot;
   end

   always @(posedge clk) begin
      if (mem_we) begin
         we_cnt <= we_cnt + 1;
         if (tb_slot) vid_we_cnt <= vid_we_cnt + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic poke(input logic [14:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_addr = a; bd_data = d; bd_en = 1'b1;
      @(negedge clk);
      bd_en = 1'b0;
   endtask

   task automatic poke2(input logic [13:0] a, input logic [7:0] d);
      @(negedge clk);
      bd2_addr = a; bd_data = d; bd2_en = 1'b1;
      @(negedge clk);
      bd2_en = 1'b0;
   endtask

   task automatic wait_cpu_slot();
      @(negedge clk);
      for (int i = 0; i < 4 && tb_slot; i++) @(negedge clk);
   endtask

   task automatic wait_video_slot();
      @(negedge clk);
      for (int i = 0; i < 4 && !tb_slot; i++) @(negedge clk);
   endtask

   // Issue one request just before a CPU-slot edge; clks = edges until ack is seen.
   task automatic access(input logic we, input logic bm, input logic [0:0] pix,
                         input logic [14:0] addr, input logic [7:0] din,
                         output int clks, output logic [7:0] dout);
      logic ok;
      wait_cpu_slot();
      cpu_we = we; cpu_bitmode = bm; cpu_pix = pix; cpu_addr = addr; cpu_din = din;
      cpu_req = 1'b1;
      clks = 0; ok = 1'b0;
      while (!ok && clks < 20) begin
         @(posedge clk); clks++;
         @(negedge clk);
         if (cpu_ack === 1'b1) ok = 1'b1;
      end
      cpu_req = 1'b0;
      dout = cpu_dout;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ack_timeout addr=%h: no ack within %0d clks", addr, clks);
      end
   endtask

   task automatic check_ack_drop(input string name);
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL %s_ack_pulse: cpu_ack=%b one clk after ack, want 0", name, cpu_ack);
      end
   endtask

   task automatic test_reset();
      int clks;
      RESETn = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         ce = 1'($urandom); cpu_req = 1'($urandom); cpu_we = 1'($urandom);
         cpu_bitmode = 1'($urandom); cpu_pix = 1'($urandom);
         cpu_addr = 15'($urandom); cpu_din = 8'($urandom);
         hs = 8'($urandom); vs = 8'($urandom);
         #1;
         checks++;
         if (cpu_ack !== 1'b0 || cpu_dout !== 8'h00 || pix_out !== 4'h0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dout=%h pix=%h we=%b, want 0 0 0 0",
                     cpu_ack, cpu_dout, pix_out, mem_we);
         end
      end
      // first ce after release must be a CPU slot: a plain write strobes at once
      @(negedge clk);
      ce = 1'b1; hs = 8'h00; vs = 8'h00;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_bitmode = 1'b0; cpu_addr = 15'h3000; cpu_din = 8'h11;
      RESETn = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_slot: mem_we=%b before first edge, want 1", mem_we);
      end
      clks = 0;
      while (cpu_ack !== 1'b1 && clks < 10) begin
         @(negedge clk); clks++;
      end
      cpu_req = 1'b0;
      checks++;
      if (ram[15'h3000] !== 8'h11 || clks != 1) begin
         errors++;
         $display("FAIL reset_first_write: ram=%h clks=%0d, want 11 1", ram[15'h3000], clks);
      end
   endtask

   task automatic test_write_read();
      int clks, we0;
      logic [7:0] d;
      we0 = we_cnt;
      access(1'b1, 1'b0, 1'b0, 15'h1234, 8'hA5, clks, d);
      checks++;
      if (clks != 1) begin
         errors++;
         $display("FAIL wr_latency: %0d clks, want 1", clks);
      end
      check_ack_drop("wr");
      checks++;
      if (we_cnt - we0 != 1 || ram[15'h1234] !== 8'hA5) begin
         errors++;
         $display("FAIL wr_strobe: strobes=%0d ram=%h, want 1 a5", we_cnt - we0, ram[15'h1234]);
      end
      access(1'b0, 1'b0, 1'b0, 15'h1234, 8'h00, clks, d);
      checks++;
      if (clks != 2 || d !== 8'hA5) begin
         errors++;
         $display("FAIL rd_plain: clks=%0d dout=%h, want 2 a5", clks, d);
      end
      check_ack_drop("rd");
   endtask

   task automatic test_bitmode();
      int clks;
      logic [7:0] d;
      access(1'b1, 1'b1, 1'b1, 15'h1234, 8'h70, clks, d);
      checks++;
      if (clks != 3 || ram[15'h1234] !== 8'hA7) begin
         errors++;
         $display("FAIL bm_write: clks=%0d ram=%h, want 3 a7", clks, ram[15'h1234]);
      end
      check_ack_drop("bm_wr");
      access(1'b0, 1'b1, 1'b1, 15'h1234, 8'h00, clks, d);
      checks++;
      if (clks != 2 || d !== 8'h70) begin
         errors++;
         $display("FAIL bm_read_pix1: clks=%0d dout=%h, want 2 70", clks, d);
      end
      access(1'b0, 1'b1, 1'b0, 15'h1234, 8'h00, clks, d);
      checks++;
      if (d !== 8'hA0) begin
         errors++;
         $display("FAIL bm_read_pix0: dout=%h, want a0", d);
      end
   endtask

   task automatic test_protect();
      int clks, we0;
      logic [7:0] d;
      poke(15'h0123, 8'h5A);
      we0 = we_cnt;
      access(1'b1, 1'b1, 1'b0, 15'h0123, 8'hF0, clks, d);
      repeat (3) @(negedge clk);
      checks++;
      if (clks != 2 || we_cnt != we0 || ram[15'h0123] !== 8'h5A) begin
         errors++;
         $display("FAIL protect: clks=%0d strobes=%0d ram=%h, want 2 0 5a",
                  clks, we_cnt - we0, ram[15'h0123]);
      end
   endtask

   task automatic test_video();
      logic [7:0] hs_v [2];
      logic [3:0] exp_v [2];
      hs_v[0] = 8'h0B; exp_v[0] = 4'hC;
      hs_v[1] = 8'h0A; exp_v[1] = 4'h3;
      poke(15'h0805, 8'h3C);
      for (int i = 0; i < 2; i++) begin
         wait_video_slot();
         vs = 8'h10; hs = hs_v[i];
         cpu_we = 1'b1; cpu_bitmode = 1'b0; cpu_addr = 15'h2000 + 15'(i); cpu_din = 8'h40 + 8'(i);
         cpu_req = 1'b1;
         @(posedge clk); @(posedge clk); @(negedge clk);
         cpu_req = 1'b0;
         checks++;
         if (pix_out !== exp_v[i]) begin
            errors++;
            $display("FAIL video4_hs%h: pix_out=%h, want %h", hs_v[i], pix_out, exp_v[i]);
         end
         checks++;
         if (cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL video_cpu_ack%0d: cpu_ack=%b, want 1", i, cpu_ack);
         end
      end
      @(negedge clk);
      checks++;
      if (ram[15'h2000] !== 8'h40 || ram[15'h2001] !== 8'h41 || vid_we_cnt != 0) begin
         errors++;
         $display("FAIL video_cpu_writes: ram=%h %h video-slot strobes=%0d, want 40 41 0",
                  ram[15'h2000], ram[15'h2001], vid_we_cnt);
      end
      poke2(14'h0405, 8'hE4);
      for (int k = 0; k < 4; k++) begin
         wait_video_slot();
         vs = 8'h10; hs = {6'h05, 2'(k)};
         @(posedge clk); @(posedge clk); @(negedge clk);
         checks++;
         if (pix_out2 !== 2'(3 - k)) begin
            errors++;
            $display("FAIL video2_idx%0d: pix_out=%h, want %h", k, pix_out2, 2'(3 - k));
         end
      end
   endtask

   task automatic test_mid_reset();
      int clks, we0, acks;
      logic [7:0] d;
      we0 = we_cnt;
      wait_cpu_slot();
      cpu_we = 1'b1; cpu_bitmode = 1'b1; cpu_pix = 1'b0; cpu_addr = 15'h1234; cpu_din = 8'h10;
      cpu_req = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      RESETn = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0) begin
         errors++;
         $display("FAIL midreset_we: mem_we=%b in reset, want 0", mem_we);
      end
      acks = 0;
      repeat (2) begin
         @(negedge clk);
         if (cpu_ack !== 1'b0) acks++;
      end
      cpu_req = 1'b0;
      @(negedge clk);
      RESETn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (cpu_ack !== 1'b0) acks++;
      end
      checks++;
      if (acks != 0 || we_cnt != we0 || ram[15'h1234] !== 8'hA7) begin
         errors++;
         $display("FAIL midreset_abandon: acks=%0d strobes=%0d ram=%h, want 0 0 a7",
                  acks, we_cnt - we0, ram[15'h1234]);
      end
      access(1'b0, 1'b0, 1'b0, 15'h1234, 8'h00, clks, d);
      checks++;
      if (clks != 2 || d !== 8'hA7) begin
         errors++;
         $display("FAIL midreset_fresh_read: clks=%0d dout=%h, want 2 a7", clks, d);
      end
   endtask

   initial begin
      RESETn = 1'b0; ce = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_bitmode = 1'b0;
      cpu_pix = '0; cpu_addr = '0; cpu_din = '0; hs = '0; vs = '0;
      test_reset();
      test_write_read();
      test_bitmode();
      test_protect();
      test_video();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
